// File: rtl/lmu_measwrite_pkg.sv
// Shared sizing and FSM encoding for the LMU measurement write-side collector.
package lmu_measwrite_pkg;

  localparam int NUM_PCH    = 8;
  localparam int PCHADDR_BW = 3;
  localparam int NUM_PCHDQ  = 9;
  localparam int NUM_PCHAQ  = 8;
  localparam int PF_BW      = NUM_PCHDQ * 2;

  // Patch count in the index width plus one bit, for the out-of-range compare
  localparam logic [PCHADDR_BW:0] NUM_PCH_W = NUM_PCH[PCHADDR_BW:0];

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FLUSH   = 2'd2
  } state_t;

endpackage

// File: rtl/lmu_measwrite_if.sv
// Slice ingress and assembled-array egress bundle for lmu_measwrite.
// slave: the collector; master: the producer/consumer pair around it.
interface lmu_measwrite_if;
  import lmu_measwrite_pkg::*;

  logic                           in_valid;
  logic                           in_ready;
  logic [PCHADDR_BW-1:0]          pchidx;
  logic [NUM_PCHDQ-1:0]           dqmeas_array_pch;
  logic [NUM_PCHAQ-1:0]           aqmeas_array_pch;
  logic [PF_BW-1:0]               pf_array_pch;

  logic                           out_valid;
  logic                           out_ready;
  logic [NUM_PCH*NUM_PCHDQ-1:0]   dqmeas_array_ing;
  logic [NUM_PCH*NUM_PCHAQ-1:0]   aqmeas_array_ing;
  logic [NUM_PCH*PF_BW-1:0]       pf_array_ing;

  modport slave (
    input  in_valid, pchidx, dqmeas_array_pch, aqmeas_array_pch, pf_array_pch,
    input  out_ready,
    output in_ready, out_valid, dqmeas_array_ing, aqmeas_array_ing, pf_array_ing
  );

  modport master (
    output in_valid, pchidx, dqmeas_array_pch, aqmeas_array_pch, pf_array_pch,
    output out_ready,
    input  in_ready, out_valid, dqmeas_array_ing, aqmeas_array_ing, pf_array_ing
  );

endinterface

// File: rtl/lmu_measwrite_slotwrite.sv
// lmu_slotwrite: NUM_SLOT registers of DATA_WIDTH bits, flattened with slot 0
// at the LSBs. One slot is written per cycle, either overwritten or XORed with
// the incoming data; clr zeroes every slot.
module lmu_slotwrite #(
  parameter int NUM_SLOT   = 8,
  parameter int DATA_WIDTH = 9,
  parameter int IDX_BW     = 3,
  parameter bit XOR_MODE   = 1'b0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clr,
  input  logic                           wr_en,
  input  logic [IDX_BW-1:0]              wr_idx,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  output logic [NUM_SLOT*DATA_WIDTH-1:0] data_out
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOT; gi++) begin : g_slot
      localparam logic [IDX_BW-1:0] SLOT_IDX = IDX_BW'(gi);
      logic [DATA_WIDTH-1:0] slot_reg;

      // Per-slot register: clear has priority, then an indexed write
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          slot_reg <= '0;
        end else if (clr) begin
          slot_reg <= '0;
        end else if (wr_en && (wr_idx == SLOT_IDX)) begin
          slot_reg <= XOR_MODE ? (slot_reg ^ wr_data) : wr_data;
        end
      end

      assign data_out[gi*DATA_WIDTH +: DATA_WIDTH] = slot_reg;
    end
  endgenerate

endmodule

// File: rtl/lmu_measwrite.sv
// lmu_measwrite: collects per-patch measurement / Pauli-frame slices into the
// ingress-wide arrays and hands the assembled arrays downstream once every
// patch of the round's mask has been written.
// Optional build macro LMU_MEASWR_XOR_EN: Pauli-frame slices accumulate by XOR
// and no array is cleared at start (meas slices still overwrite).
module lmu_measwrite
  import lmu_measwrite_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [NUM_PCH-1:0] pch_mask,
  lmu_measwrite_if.slave     bus,
  output logic               err
);

  localparam logic [NUM_PCH-1:0] ONE_HOT0 = {{(NUM_PCH-1){1'b0}}, 1'b1};

`ifdef LMU_MEASWR_XOR_EN
  localparam bit PF_XOR = 1'b1;
`else
  localparam bit PF_XOR = 1'b0;
`endif

  state_t             state_reg, state_next;
  logic [NUM_PCH-1:0] mask_reg;
  logic [NUM_PCH-1:0] written_reg;
  logic               err_reg;

  logic               in_ready_int;
  logic               out_valid_int;
  logic               start_go;
  logic               in_fire;
  logic               out_fire;
  logic               idx_in_range;
  logic [NUM_PCH-1:0] idx_onehot;
  logic               slice_ok;
  logic               wr_en;
  logic               round_done;
  logic               arr_clr;

  assign start_go     = (state_reg == IDLE) && start;
  assign in_fire      = bus.in_valid && in_ready_int;
  assign out_fire     = out_valid_int && bus.out_ready;
  assign idx_in_range = ({1'b0, bus.pchidx} < NUM_PCH_W);
  assign idx_onehot   = idx_in_range ? (ONE_HOT0 << bus.pchidx) : '0;
  // A slice lands only if its slot is in range, expected, and not yet written
  assign slice_ok     = idx_in_range && (|(idx_onehot & mask_reg)) &&
                        !(|(idx_onehot & written_reg));
  assign wr_en        = in_fire && slice_ok;
  assign round_done   = wr_en && ((written_reg | idx_onehot) == mask_reg);

`ifdef LMU_MEASWR_XOR_EN
  assign arr_clr = 1'b0;
`else
  assign arr_clr = start_go;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = (pch_mask == '0) ? FLUSH : COLLECT;
        end
      end
      COLLECT: begin
        if (round_done) begin
          state_next = FLUSH;
        end
      end
      FLUSH: begin
        if (out_fire) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs are pure state decodes, independent of in_valid
  always_comb begin
    in_ready_int  = 1'b0;
    out_valid_int = 1'b0;
    case (state_reg)
      COLLECT: in_ready_int  = 1'b1;
      FLUSH:   out_valid_int = 1'b1;
      default: ;
    endcase
  end

  // Round bookkeeping: expected mask, written bitmap, sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_reg    <= '0;
      written_reg <= '0;
      err_reg     <= 1'b0;
    end else begin
      if (start_go) begin
        mask_reg    <= pch_mask;
        written_reg <= '0;
      end else if (wr_en) begin
        written_reg <= written_reg | idx_onehot;
      end
      if (in_fire && !slice_ok) begin
        err_reg <= 1'b1;
      end
    end
  end

  lmu_slotwrite #(
    .NUM_SLOT   (NUM_PCH),
    .DATA_WIDTH (NUM_PCHDQ),
    .IDX_BW     (PCHADDR_BW),
    .XOR_MODE   (1'b0)
  ) u_dq (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (arr_clr),
    .wr_en    (wr_en),
    .wr_idx   (bus.pchidx),
    .wr_data  (bus.dqmeas_array_pch),
    .data_out (bus.dqmeas_array_ing)
  );

  lmu_slotwrite #(
    .NUM_SLOT   (NUM_PCH),
    .DATA_WIDTH (NUM_PCHAQ),
    .IDX_BW     (PCHADDR_BW),
    .XOR_MODE   (1'b0)
  ) u_aq (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (arr_clr),
    .wr_en    (wr_en),
    .wr_idx   (bus.pchidx),
    .wr_data  (bus.aqmeas_array_pch),
    .data_out (bus.aqmeas_array_ing)
  );

  lmu_slotwrite #(
    .NUM_SLOT   (NUM_PCH),
    .DATA_WIDTH (PF_BW),
    .IDX_BW     (PCHADDR_BW),
    .XOR_MODE   (PF_XOR)
  ) u_pf (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (arr_clr),
    .wr_en    (wr_en),
    .wr_idx   (bus.pchidx),
    .wr_data  (bus.pf_array_pch),
    .data_out (bus.pf_array_ing)
  );

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = out_valid_int;
  assign err           = err_reg;

endmodule

// File: tb/tb_lmu_measwrite.sv
// Directed bench for lmu_measwrite; expectations are hand-computed constants.
module tb_lmu_measwrite;
  import lmu_measwrite_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] pch_mask;
  logic       err;
  int         total;
  int         bad;

  lmu_measwrite_if bus_if ();

  lmu_measwrite dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .pch_mask (pch_mask),
    .bus      (bus_if),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_slice(input logic [2:0] idx, input logic [8:0] dq,
                             input logic [7:0] aq, input logic [17:0] pf);
    bus_if.in_valid         = 1'b1;
    bus_if.pchidx           = idx;
    bus_if.dqmeas_array_pch = dq;
    bus_if.aqmeas_array_pch = aq;
    bus_if.pf_array_pch     = pf;
    $display("slice pch=%0d dq=%h aq=%h pf=%h", idx, dq, aq, pf);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++; if (bus_if.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus_if.out_valid); end
    total++; if (bus_if.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", bus_if.in_ready); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
    total++; if (bus_if.dqmeas_array_ing !== 72'h0) begin bad++; $display("FAIL reset_dq got=%h want=0", bus_if.dqmeas_array_ing); end
    total++; if (bus_if.aqmeas_array_ing !== 64'h0) begin bad++; $display("FAIL reset_aq got=%h want=0", bus_if.aqmeas_array_ing); end
    total++; if (bus_if.pf_array_ing !== 144'h0) begin bad++; $display("FAIL reset_pf got=%h want=0", bus_if.pf_array_ing); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    total++; if (bus_if.in_ready !== 1'b0) begin bad++; $display("FAIL reset_idle_in_ready got=%b want=0", bus_if.in_ready); end
  endtask

  task automatic test_basic();
    logic [71:0]  dq_exp;
    logic [63:0]  aq_exp;
    logic [143:0] pf_exp;
    dq_exp = (72'h0A5 << 18) | 72'h1FF;
    aq_exp = (64'hC3 << 16) | 64'h3C;
    pf_exp = (144'h15555 << 36) | 144'h2AAAA;
    start = 1'b1; pch_mask = 8'h05;
    tick();
    start = 1'b0; pch_mask = 8'h00;
    total++; if (bus_if.in_ready !== 1'b1) begin bad++; $display("FAIL basic_in_ready got=%b want=1", bus_if.in_ready); end
    drive_slice(3'd0, 9'h1FF, 8'h3C, 18'h2AAAA);
    tick();
    total++; if (bus_if.out_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%b want=0", bus_if.out_valid); end
    drive_slice(3'd2, 9'h0A5, 8'hC3, 18'h15555);
    tick();
    bus_if.in_valid = 1'b0;
    total++; if (bus_if.out_valid !== 1'b1) begin bad++; $display("FAIL basic_out_valid got=%b want=1", bus_if.out_valid); end
    total++; if (bus_if.in_ready !== 1'b0) begin bad++; $display("FAIL basic_in_ready_drop got=%b want=0", bus_if.in_ready); end
    total++; if (bus_if.dqmeas_array_ing !== dq_exp) begin bad++; $display("FAIL basic_dq got=%h want=%h", bus_if.dqmeas_array_ing, dq_exp); end
    total++; if (bus_if.aqmeas_array_ing !== aq_exp) begin bad++; $display("FAIL basic_aq got=%h want=%h", bus_if.aqmeas_array_ing, aq_exp); end
    total++; if (bus_if.pf_array_ing !== pf_exp) begin bad++; $display("FAIL basic_pf got=%h want=%h", bus_if.pf_array_ing, pf_exp); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL basic_err got=%b want=0", err); end
  endtask

  task automatic test_backpressure();
    logic [71:0] dq_exp;
    dq_exp = (72'h0A5 << 18) | 72'h1FF;
    bus_if.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      start    = (i == 2);
      pch_mask = (i == 2) ? 8'hFF : 8'h00;
      tick();
      total++; if (bus_if.out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid cyc=%0d got=%b want=1", i, bus_if.out_valid); end
      total++; if (bus_if.dqmeas_array_ing !== dq_exp) begin bad++; $display("FAIL bp_hold_dq cyc=%0d got=%h want=%h", i, bus_if.dqmeas_array_ing, dq_exp); end
    end
    start = 1'b0; pch_mask = 8'h00;
    bus_if.out_ready = 1'b1;
    tick();
    bus_if.out_ready = 1'b0;
    total++; if (bus_if.out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid got=%b want=0", bus_if.out_valid); end
    total++; if (bus_if.in_ready !== 1'b0) begin bad++; $display("FAIL bp_idle_in_ready got=%b want=0", bus_if.in_ready); end
    tick();
    total++; if (bus_if.dqmeas_array_ing !== dq_exp) begin bad++; $display("FAIL bp_idle_dq got=%h want=%h", bus_if.dqmeas_array_ing, dq_exp); end
    total++; if (bus_if.in_ready !== 1'b0) begin bad++; $display("FAIL bp_start_ignored got=%b want=0", bus_if.in_ready); end
  endtask

  task automatic test_errors();
    start = 1'b1; pch_mask = 8'h01;
    tick();
    start = 1'b0; pch_mask = 8'h00;
    drive_slice(3'd3, 9'h1AB, 8'h00, 18'h00000);
    tick();
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_unmasked got=%b want=1", err); end
    total++; if (bus_if.in_ready !== 1'b1) begin bad++; $display("FAIL err_still_collect got=%b want=1", bus_if.in_ready); end
    total++; if (bus_if.dqmeas_array_ing[35:27] !== 9'h000) begin bad++; $display("FAIL err_slot3 got=%h want=000", bus_if.dqmeas_array_ing[35:27]); end
    drive_slice(3'd0, 9'h055, 8'h00, 18'h00000);
    tick();
    total++; if (bus_if.out_valid !== 1'b1) begin bad++; $display("FAIL err_round_done got=%b want=1", bus_if.out_valid); end
    total++; if (bus_if.in_ready !== 1'b0) begin bad++; $display("FAIL err_flush_in_ready got=%b want=0", bus_if.in_ready); end
    drive_slice(3'd0, 9'h0FF, 8'h00, 18'h00000);
    tick();
    bus_if.in_valid = 1'b0;
    total++; if (bus_if.dqmeas_array_ing[8:0] !== 9'h055) begin bad++; $display("FAIL err_dup_dropped got=%h want=055", bus_if.dqmeas_array_ing[8:0]); end
    total++; if (bus_if.dqmeas_array_ing[35:27] !== 9'h000) begin bad++; $display("FAIL err_slot3_end got=%h want=000", bus_if.dqmeas_array_ing[35:27]); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b want=1", err); end
    bus_if.out_ready = 1'b1;
    tick();
    bus_if.out_ready = 1'b0;
  endtask

  task automatic test_empty_mask();
    start = 1'b1; pch_mask = 8'h00;
    tick();
    start = 1'b0;
    total++; if (bus_if.out_valid !== 1'b1) begin bad++; $display("FAIL empty_valid got=%b want=1", bus_if.out_valid); end
`ifndef LMU_MEASWR_XOR_EN
    total++; if (bus_if.dqmeas_array_ing !== 72'h0) begin bad++; $display("FAIL empty_dq got=%h want=0", bus_if.dqmeas_array_ing); end
    total++; if (bus_if.aqmeas_array_ing !== 64'h0) begin bad++; $display("FAIL empty_aq got=%h want=0", bus_if.aqmeas_array_ing); end
    total++; if (bus_if.pf_array_ing !== 144'h0) begin bad++; $display("FAIL empty_pf got=%h want=0", bus_if.pf_array_ing); end
`endif
    bus_if.out_ready = 1'b1;
    tick();
    bus_if.out_ready = 1'b0;
    total++; if (bus_if.out_valid !== 1'b0) begin bad++; $display("FAIL empty_drain got=%b want=0", bus_if.out_valid); end
  endtask

  task automatic test_back_to_back();
    start = 1'b1; pch_mask = 8'h90;
    tick();
    start = 1'b0; pch_mask = 8'h00;
    drive_slice(3'd7, 9'h1C3, 8'h81, 18'h3FFFF);
    tick();
    drive_slice(3'd4, 9'h111, 8'h7E, 18'h00F0F);
    tick();
    total++; if (bus_if.out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid got=%b want=1", bus_if.out_valid); end
    total++; if (bus_if.in_ready !== 1'b0) begin bad++; $display("FAIL b2b_in_ready got=%b want=0", bus_if.in_ready); end
    bus_if.in_valid = 1'b0;
    total++; if (bus_if.dqmeas_array_ing[71:63] !== 9'h1C3) begin bad++; $display("FAIL b2b_dq7 got=%h want=1c3", bus_if.dqmeas_array_ing[71:63]); end
    total++; if (bus_if.dqmeas_array_ing[44:36] !== 9'h111) begin bad++; $display("FAIL b2b_dq4 got=%h want=111", bus_if.dqmeas_array_ing[44:36]); end
    total++; if (bus_if.aqmeas_array_ing[63:56] !== 8'h81) begin bad++; $display("FAIL b2b_aq7 got=%h want=81", bus_if.aqmeas_array_ing[63:56]); end
    total++; if (bus_if.aqmeas_array_ing[39:32] !== 8'h7E) begin bad++; $display("FAIL b2b_aq4 got=%h want=7e", bus_if.aqmeas_array_ing[39:32]); end
    total++; if (bus_if.pf_array_ing[143:126] !== 18'h3FFFF) begin bad++; $display("FAIL b2b_pf7 got=%h want=3ffff", bus_if.pf_array_ing[143:126]); end
    total++; if (bus_if.pf_array_ing[89:72] !== 18'h00F0F) begin bad++; $display("FAIL b2b_pf4 got=%h want=00f0f", bus_if.pf_array_ing[89:72]); end
`ifndef LMU_MEASWR_XOR_EN
    total++; if (bus_if.dqmeas_array_ing !== ((72'h1C3 << 63) | (72'h111 << 36))) begin bad++; $display("FAIL b2b_dq_full got=%h", bus_if.dqmeas_array_ing); end
    total++; if (bus_if.pf_array_ing !== ((144'h3FFFF << 126) | (144'h00F0F << 72))) begin bad++; $display("FAIL b2b_pf_full got=%h", bus_if.pf_array_ing); end
`endif
    bus_if.out_ready = 1'b1;
    tick();
    bus_if.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_round();
    start = 1'b1; pch_mask = 8'hFF;
    tick();
    start = 1'b0; pch_mask = 8'h00;
    for (int i = 0; i < 3; i++) begin
      drive_slice(3'(i), 9'h1F0 + 9'(i), 8'hA0 + 8'(i), 18'h10000 + 18'(i));
      tick();
    end
    bus_if.in_valid = 1'b0;
    total++; if (bus_if.out_valid !== 1'b0) begin bad++; $display("FAIL mid_no_valid got=%b want=0", bus_if.out_valid); end
    total++; if (bus_if.dqmeas_array_ing[26:18] !== 9'h1F2) begin bad++; $display("FAIL mid_dq2 got=%h want=1f2", bus_if.dqmeas_array_ing[26:18]); end
    rst_n = 1'b0;
    #1;
    total++; if (bus_if.out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b want=0", bus_if.out_valid); end
    total++; if (bus_if.in_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_in_ready got=%b want=0", bus_if.in_ready); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL mid_rst_err got=%b want=0", err); end
    total++; if (bus_if.dqmeas_array_ing !== 72'h0) begin bad++; $display("FAIL mid_rst_dq got=%h want=0", bus_if.dqmeas_array_ing); end
    total++; if (bus_if.aqmeas_array_ing !== 64'h0) begin bad++; $display("FAIL mid_rst_aq got=%h want=0", bus_if.aqmeas_array_ing); end
    total++; if (bus_if.pf_array_ing !== 144'h0) begin bad++; $display("FAIL mid_rst_pf got=%h want=0", bus_if.pf_array_ing); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    tick();
    total++; if (bus_if.in_ready !== 1'b0) begin bad++; $display("FAIL mid_idle_in_ready got=%b want=0", bus_if.in_ready); end
    total++; if (bus_if.out_valid !== 1'b0) begin bad++; $display("FAIL mid_idle_valid got=%b want=0", bus_if.out_valid); end
  endtask

  task automatic test_pf_rounds();
    logic [17:0] pf_exp2;
`ifdef LMU_MEASWR_XOR_EN
    pf_exp2 = 18'h00002;
`else
    pf_exp2 = 18'h00001;
`endif
    start = 1'b1; pch_mask = 8'h02;
    tick();
    start = 1'b0; pch_mask = 8'h00;
    drive_slice(3'd1, 9'h000, 8'h00, 18'h00003);
    tick();
    bus_if.in_valid = 1'b0;
    total++; if (bus_if.pf_array_ing[35:18] !== 18'h00003) begin bad++; $display("FAIL pf_round1 got=%h want=00003", bus_if.pf_array_ing[35:18]); end
    bus_if.out_ready = 1'b1;
    tick();
    bus_if.out_ready = 1'b0;
    start = 1'b1; pch_mask = 8'h02;
    tick();
    start = 1'b0; pch_mask = 8'h00;
    drive_slice(3'd1, 9'h000, 8'h00, 18'h00001);
    tick();
    bus_if.in_valid = 1'b0;
    total++; if (bus_if.out_valid !== 1'b1) begin bad++; $display("FAIL pf_round2_valid got=%b want=1", bus_if.out_valid); end
    total++; if (bus_if.pf_array_ing[35:18] !== pf_exp2) begin bad++; $display("FAIL pf_round2 got=%h want=%h", bus_if.pf_array_ing[35:18], pf_exp2); end
    bus_if.out_ready = 1'b1;
    tick();
    bus_if.out_ready = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    start = 1'b0;
    pch_mask = 8'h00;
    bus_if.in_valid         = 1'b0;
    bus_if.pchidx           = 3'd0;
    bus_if.dqmeas_array_pch = '0;
    bus_if.aqmeas_array_pch = '0;
    bus_if.pf_array_pch     = '0;
    bus_if.out_ready        = 1'b0;

    test_reset();
    test_basic();
    test_backpressure();
    test_errors();
    test_empty_mask();
    test_back_to_back();
    test_reset_mid_round();
    test_pf_rounds();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
